// File: rtl/execute_pkg.sv
// Shared constants and enums for the execute (EX) stage of the RV32 pipeline.
package execute_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } data_size_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Encoded in RV32M funct3 order: bit 2 set means a divide-family op.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, one step per clock, sign fix-up applied while in DONE.
module execute_muldiv_unit
  import execute_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(MD_STEPS);

  md_state_e         state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   divisor_r;
  md_op_e            op_r;
  logic              neg_q_r;
  logic              neg_r_r;

  logic              signed_a_s, signed_b_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     mul_sum_s, div_diff_s;
  logic [2*XLEN-1:0] step_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  // Operand signedness for the op being started
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (op_i)
      MD_MULH, MD_DIV, MD_REM: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      MD_MULHSU: signed_a_s = 1'b1;
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
  end

  assign a_neg_s = signed_a_s & a_i[XLEN-1];
  assign b_neg_s = signed_b_s & b_i[XLEN-1];
  assign mag_a_s = a_neg_s ? -a_i : a_i;
  assign mag_b_s = b_neg_s ? -b_i : b_i;

  // One iteration: upper half of acc is partial product / partial remainder
  assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, divisor_r} : '0);
  assign div_diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, divisor_r};

  // Step selection between multiply and divide datapaths
  always_comb begin
    if (!op_r[2]) begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end else if (div_diff_s[XLEN]) begin
      step_s = {acc_r[2*XLEN-2:0], 1'b0};
    end else begin
      step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end
  end

  assign prod_s = neg_q_r ? -acc_r : acc_r;
  assign quo_s  = neg_q_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
  assign rem_s  = neg_r_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];

  // Final result selection
  always_comb begin
    case (op_r)
      MD_MUL:                       result_o = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_o = quo_s;
      MD_REM, MD_REMU:              result_o = rem_s;
      default:                      result_o = '0;
    endcase
  end

  assign done_o = (state_r == MD_DONE);

  // Control FSM, iteration counter and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      cnt_r     <= '0;
      acc_r     <= '0;
      divisor_r <= '0;
      op_r      <= MD_MUL;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else if (flush_i) begin
      state_r <= MD_IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start_i) begin
            state_r   <= MD_RUN;
            cnt_r     <= '0;
            acc_r     <= {{XLEN{1'b0}}, mag_a_s};
            divisor_r <= mag_b_s;
            op_r      <= op_i;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
          end
        end
        MD_RUN: begin
          acc_r <= step_s;
          if (cnt_r == CNT_W'(MD_STEPS - 1)) begin
            state_r <= MD_DONE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        MD_DONE: begin
          if (!stall_i) begin
            state_r <= MD_IDLE;
          end
        end
        default: state_r <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute.sv
// EX stage: single-cycle ALU, divide special cases and the EX/MEM register.
// RV32M support is built only when MULDIV_EN is defined.
module execute
  import execute_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  alu_op_e         alu_op_i,
  input  logic            is_muldiv_i,
  input  md_op_e          md_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      sel_rd_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  data_size_e      mem_size_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic [XLEN-1:0] result_bypass_o,
  output logic [4:0]      sel_rd_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output data_size_e      mem_size_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] alu_res_s;
  logic [XLEN-1:0] md_res_s;
  logic            busy_s;

  // Single-cycle integer ALU
  always_comb begin
    case (alu_op_i)
      ALU_ADD:  alu_res_s = op_a_i + op_b_i;
      ALU_SUB:  alu_res_s = op_a_i - op_b_i;
      ALU_SLL:  alu_res_s = op_a_i << op_b_i[4:0];
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
      ALU_XOR:  alu_res_s = op_a_i ^ op_b_i;
      ALU_SRL:  alu_res_s = op_a_i >> op_b_i[4:0];
      ALU_SRA:  alu_res_s = $signed(op_a_i) >>> op_b_i[4:0];
      ALU_OR:   alu_res_s = op_a_i | op_b_i;
      ALU_AND:  alu_res_s = op_a_i & op_b_i;
      default:  alu_res_s = '0;
    endcase
  end

`ifdef MULDIV_EN
  logic            is_div_s, div_zero_s, div_ovf_s, special_s, md_done_s;
  logic [XLEN-1:0] special_res_s, md_unit_res_s;

  // Zero divisors and INT_MIN / -1 resolve without entering the iterative unit
  assign is_div_s   = md_op_i[2];
  assign div_zero_s = (op_b_i == '0);
  assign div_ovf_s  = ~md_op_i[0] & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
  assign special_s  = is_div_s & (div_zero_s | div_ovf_s);

  // Fixed results for the special divide cases
  always_comb begin
    case (md_op_i)
      MD_DIV:  special_res_s = div_zero_s ? '1 : {1'b1, {(XLEN-1){1'b0}}};
      MD_DIVU: special_res_s = '1;
      MD_REM:  special_res_s = div_zero_s ? op_a_i : '0;
      MD_REMU: special_res_s = op_a_i;
      default: special_res_s = '0;
    endcase
  end

  execute_muldiv_unit #(
    .XLEN     (XLEN),
    .MD_STEPS (MD_STEPS)
  ) u_muldiv_unit (
    .clk      (clk),
    .rst      (rst),
    .start_i  (valid_i & is_muldiv_i & ~special_s),
    .flush_i  (flush_i),
    .stall_i  (stall_i),
    .op_i     (md_op_i),
    .a_i      (op_a_i),
    .b_i      (op_b_i),
    .done_o   (md_done_s),
    .result_o (md_unit_res_s)
  );

  assign busy_s   = valid_i & is_muldiv_i & ~special_s & ~md_done_s & ~flush_i;
  assign md_res_s = special_s ? special_res_s : md_unit_res_s;
`else
  logic unused_md_op_s;

  assign unused_md_op_s = ^md_op_i;
  assign busy_s         = 1'b0;
  assign md_res_s       = '0;
`endif

  assign busy_o          = busy_s;
  assign result_bypass_o = is_muldiv_i ? md_res_s : alu_res_s;

  // EX/MEM pipeline register: flush > stall > busy bubble > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_rd_o     <= 5'd0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_size_o   <= SIZE_BYTE;
      alu_result_o <= '0;
      data_o       <= '0;
    end else if (flush_i || (!stall_i && busy_s)) begin
      sel_rd_o     <= 5'd0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_size_o   <= SIZE_BYTE;
      alu_result_o <= '0;
      data_o       <= '0;
    end else if (!stall_i) begin
      sel_rd_o     <= sel_rd_i;
      mem_re_o     <= mem_re_i;
      mem_we_o     <= mem_we_i;
      mem_size_o   <= mem_size_i;
      alu_result_o <= result_bypass_o;
      data_o       <= rs2_data_i;
    end
  end

endmodule
